phase_accumulator_mc: RTL and testbench

Multi-channel signed accumulator (phase/count accumulator) for the CORDIC datapath. It holds `N_CH` independent accumulators, each `N_FRAC+1` bits wide. On each strobe it updates one addressed channel by adding, or loading, an addend, with per-strobe wrap or saturate behaviour. The registered result, channel tag, overflow flag and a one-cycle valid strobe feed the downstream CORDIC stage.

---
 rtl/phase_accumulator_mc_if.sv | 27 ++
 rtl/phase_accumulator_mc.sv | 83 ++++++++
 tb/tb_phase_accumulator_mc.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/phase_accumulator_mc_if.sv
// Request/report bundle between a phase_accumulator_mc and its controller.
// The controller (master) issues strobes; the accumulator (slave) reports results.
interface phase_accumulator_mc_if #(
    parameter int W    = 8,
    parameter int CH_W = 2
);
    logic                   clear_i;
    logic                   next_data_strobe_i;
    logic        [CH_W-1:0] ch_i;
    logic signed [W-1:0]    addend_i;
    logic                   load_i;
    logic                   sat_mode_i;
    logic signed [W-1:0]    data_o;
    logic        [CH_W-1:0] ch_o;
    logic                   overflow_o;
    logic                   data_out_valid_strobe_o;

    modport master (
        output clear_i, next_data_strobe_i, ch_i, addend_i, load_i, sat_mode_i,
        input  data_o, ch_o, overflow_o, data_out_valid_strobe_o
    );

    modport slave (
        input  clear_i, next_data_strobe_i, ch_i, addend_i, load_i, sat_mode_i,
        output data_o, ch_o, overflow_o, data_out_valid_strobe_o
    );
endinterface

// File: rtl/phase_accumulator_mc.sv
// Multi-channel signed phase/count accumulator: one addressed channel per strobe,
// add or load, wrap or saturate, with a registered one-cycle result report.
module phase_accumulator_mc #(
    parameter int N_FRAC = 7,
    parameter int N_CH   = 4,
    parameter int CH_W   = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    phase_accumulator_mc_if.slave   bus
);
    localparam int W = N_FRAC + 1;
    localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

    logic signed [W-1:0]    r_acc [N_CH];
    logic signed [W-1:0]    r_data;
    logic        [CH_W-1:0] r_ch;
    logic                   r_ovf;
    logic                   r_valid;

    logic signed [W-1:0]    w_cur;
    logic                   w_ch_valid;
    logic signed [W:0]      w_sum;
    logic                   w_ovf;
    logic signed [W-1:0]    w_result;

    // Channel decode by match rather than range compare, so N_CH < 2**CH_W
    // simply leaves the upper codes unmatched.
    always_comb begin
        w_cur      = '0;
        w_ch_valid = 1'b0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (32'(bus.ch_i) == k) begin
                w_cur      = r_acc[k];
                w_ch_valid = 1'b1;
            end
        end
    end

    always_comb begin
        w_sum = {w_cur[W-1], w_cur} + {bus.addend_i[W-1], bus.addend_i};
        w_ovf = 1'b0;
        if (bus.load_i) begin
            w_result = bus.addend_i;
        end else begin
            w_ovf = w_sum[W] ^ w_sum[W-1];
            if (w_ovf && bus.sat_mode_i)
                w_result = bus.addend_i[W-1] ? SAT_MIN : SAT_MAX;
            else
                w_result = w_sum[W-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned k = 0; k < N_CH; k++) r_acc[k] <= '0;
            r_data  <= '0;
            r_ch    <= '0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end else if (bus.clear_i) begin
            for (int unsigned k = 0; k < N_CH; k++) r_acc[k] <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (bus.next_data_strobe_i && w_ch_valid) begin
                for (int unsigned k = 0; k < N_CH; k++) begin
                    if (32'(bus.ch_i) == k) r_acc[k] <= w_result;
                end
                r_data  <= w_result;
                r_ch    <= bus.ch_i;
                r_ovf   <= w_ovf;
                r_valid <= 1'b1;
            end
        end
    end

    assign bus.data_o                  = r_data;
    assign bus.ch_o                    = r_ch;
    assign bus.overflow_o              = r_ovf;
    assign bus.data_out_valid_strobe_o = r_valid;
endmodule

// File: tb/tb_phase_accumulator_mc.sv
// Directed bench: 4-channel instance for the main behaviour, 3-channel
// instance for the unmapped-channel case.
module tb_phase_accumulator_mc;
    logic clk = 1'b0;
    logic rst;
    logic rst2;
    int   checks = 0;
    int   failures = 0;
    logic [11:0] exp;

    always #5 clk = ~clk;

    phase_accumulator_mc_if #(.W(8), .CH_W(2)) bus ();
    phase_accumulator_mc_if #(.W(8), .CH_W(2)) bus2 ();

    phase_accumulator_mc #(.N_FRAC(7), .N_CH(4), .CH_W(2)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus.slave)
    );
    phase_accumulator_mc #(.N_FRAC(7), .N_CH(3), .CH_W(2)) dut2 (
        .clk_i(clk), .rst_i(rst2), .bus(bus2.slave)
    );

    function automatic logic [11:0] rd();
        return {bus.data_out_valid_strobe_o, bus.overflow_o, bus.ch_o, bus.data_o};
    endfunction

    function automatic logic [11:0] rd2();
        return {bus2.data_out_valid_strobe_o, bus2.overflow_o, bus2.ch_o, bus2.data_o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic stb, input logic [1:0] ch, input int add,
                       input logic ld, input logic sat);
        bus.next_data_strobe_i = stb;
        bus.ch_i       = ch;
        bus.addend_i   = 8'(add);
        bus.load_i     = ld;
        bus.sat_mode_i = sat;
        tick();
    endtask

    task automatic drv2(input logic stb, input logic [1:0] ch, input int add,
                        input logic ld);
        bus2.next_data_strobe_i = stb;
        bus2.ch_i       = ch;
        bus2.addend_i   = 8'(add);
        bus2.load_i     = ld;
        bus2.sat_mode_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.clear_i = 1'($urandom);
            drv(1'($urandom), 2'($urandom), int'($urandom_range(0, 255)),
                1'($urandom), 1'($urandom));
            checks++;
            if (rd() !== 12'h000) begin
                failures++;
                $display("FAIL reset_hold[%0d] got=%h exp=000", i, rd());
            end
        end
        rst = 1'b0;
        bus.clear_i = 1'b0;
        drv(1, 0, 5, 0, 0);
        exp = {1'b1, 1'b0, 2'd0, 8'(5)};
        checks++;
        if (rd() !== exp) begin failures++; $display("FAIL reset_first got=%h exp=%h", rd(), exp); end
        drv(0, 0, 0, 0, 0);
        exp = {1'b0, 1'b0, 2'd0, 8'(5)};
        checks++;
        if (rd() !== exp) begin failures++; $display("FAIL reset_valid_drop got=%h exp=%h", rd(), exp); end
    endtask

    task automatic test_wrap();
        logic [11:0] e [3];
        e[0] = {1'b1, 1'b0, 2'd1, 8'(100)};
        e[1] = {1'b1, 1'b1, 2'd1, 8'(-106)};
        e[2] = {1'b1, 1'b0, 2'd1, 8'(-96)};
        drv(1, 1, 100, 1, 0);
        checks++;
        if (rd() !== e[0]) begin failures++; $display("FAIL wrap_load got=%h exp=%h", rd(), e[0]); end
        drv(1, 1, 50, 0, 0);
        checks++;
        if (rd() !== e[1]) begin failures++; $display("FAIL wrap_ovf got=%h exp=%h", rd(), e[1]); end
        drv(1, 1, 10, 0, 0);
        checks++;
        if (rd() !== e[2]) begin failures++; $display("FAIL wrap_after got=%h exp=%h", rd(), e[2]); end
    endtask

    task automatic test_saturate();
        int          add [6] = '{100, 50, -100, -50, -128, 127};
        logic [1:0]  ch  [6] = '{2, 2, 3, 3, 3, 3};
        logic        ld  [6] = '{1, 0, 1, 0, 0, 0};
        logic [11:0] e   [6];
        e[0] = {1'b1, 1'b0, 2'd2, 8'(100)};
        e[1] = {1'b1, 1'b1, 2'd2, 8'(127)};
        e[2] = {1'b1, 1'b0, 2'd3, 8'(-100)};
        e[3] = {1'b1, 1'b1, 2'd3, 8'(-128)};
        e[4] = {1'b1, 1'b1, 2'd3, 8'(-128)};
        e[5] = {1'b1, 1'b0, 2'd3, 8'(-1)};
        for (int i = 0; i < 6; i++) begin
            drv(1, ch[i], add[i], ld[i], 1);
            checks++;
            if (rd() !== e[i]) begin failures++; $display("FAIL sat[%0d] got=%h exp=%h", i, rd(), e[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  ch [4] = '{0, 1, 0, 0};
        int          ad [4] = '{1, 2, 3, 3};
        logic [11:0] e  [4];
        e[0] = {1'b1, 1'b0, 2'd0, 8'(1)};
        e[1] = {1'b1, 1'b0, 2'd1, 8'(2)};
        e[2] = {1'b1, 1'b0, 2'd0, 8'(4)};
        e[3] = {1'b1, 1'b0, 2'd0, 8'(7)};
        // start from zeroed channels; clear alone must not disturb the report
        bus.clear_i = 1'b1;
        drv(0, 0, 0, 0, 0);
        bus.clear_i = 1'b0;
        exp = {1'b0, 1'b0, 2'd3, 8'(-1)};
        checks++;
        if (rd() !== exp) begin failures++; $display("FAIL b2b_clear_hold got=%h exp=%h", rd(), exp); end
        for (int i = 0; i < 4; i++) begin
            drv(1, ch[i], ad[i], 0, 0);
            checks++;
            if (rd() !== e[i]) begin failures++; $display("FAIL b2b[%0d] got=%h exp=%h", i, rd(), e[i]); end
        end
        drv(0, 0, 0, 0, 0);
        exp = {1'b0, 1'b0, 2'd0, 8'(7)};
        checks++;
        if (rd() !== exp) begin failures++; $display("FAIL b2b_idle got=%h exp=%h", rd(), exp); end
    endtask

    task automatic test_clear_priority();
        bus.clear_i = 1'b1;
        drv(1, 0, 9, 0, 0);
        bus.clear_i = 1'b0;
        exp = {1'b0, 1'b0, 2'd0, 8'(7)};
        checks++;
        if (rd() !== exp) begin failures++; $display("FAIL clr_strobe_drop got=%h exp=%h", rd(), exp); end
        drv(1, 0, 9, 0, 0);
        exp = {1'b1, 1'b0, 2'd0, 8'(9)};
        checks++;
        if (rd() !== exp) begin failures++; $display("FAIL clr_ch0 got=%h exp=%h", rd(), exp); end
        drv(1, 1, 0, 0, 0);
        exp = {1'b1, 1'b0, 2'd1, 8'(0)};
        checks++;
        if (rd() !== exp) begin failures++; $display("FAIL clr_ch1 got=%h exp=%h", rd(), exp); end
        drv(1, 2, 5, 1, 0);
        rst = 1'b1;
        bus.clear_i = 1'b1;
        drv(1, 2, 33, 0, 1);
        rst = 1'b0;
        bus.clear_i = 1'b0;
        checks++;
        if (rd() !== 12'h000) begin failures++; $display("FAIL rst_priority got=%h exp=000", rd()); end
        drv(1, 2, 0, 0, 0);
        exp = {1'b1, 1'b0, 2'd2, 8'(0)};
        checks++;
        if (rd() !== exp) begin failures++; $display("FAIL rst_first_strobe got=%h exp=%h", rd(), exp); end
    endtask

    task automatic test_invalid_channel();
        rst2 = 1'b1;
        drv2(0, 0, 0, 0);
        rst2 = 1'b0;
        drv2(1, 2, 42, 1);
        exp = {1'b1, 1'b0, 2'd2, 8'(42)};
        checks++;
        if (rd2() !== exp) begin failures++; $display("FAIL inv_load got=%h exp=%h", rd2(), exp); end
        drv2(1, 3, 5, 1);
        exp = {1'b0, 1'b0, 2'd2, 8'(42)};
        checks++;
        if (rd2() !== exp) begin failures++; $display("FAIL inv_ignored got=%h exp=%h", rd2(), exp); end
        drv2(1, 3, 7, 0);
        drv2(1, 2, 0, 0);
        exp = {1'b1, 1'b0, 2'd2, 8'(42)};
        checks++;
        if (rd2() !== exp) begin failures++; $display("FAIL inv_ch2_kept got=%h exp=%h", rd2(), exp); end
    endtask

    initial begin
        rst  = 1'b1;
        rst2 = 1'b1;
        bus.clear_i  = 1'b0;
        bus2.clear_i = 1'b0;
        bus.next_data_strobe_i  = 1'b0;
        bus2.next_data_strobe_i = 1'b0;
        bus.ch_i = '0;  bus.addend_i = '0;  bus.load_i = 1'b0;  bus.sat_mode_i = 1'b0;
        bus2.ch_i = '0; bus2.addend_i = '0; bus2.load_i = 1'b0; bus2.sat_mode_i = 1'b0;
        test_reset();
        test_wrap();
        test_saturate();
        test_back_to_back();
        test_clear_priority();
        test_invalid_channel();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
